// File: rtl/apb_decode_pkg.sv
// apb_decode_pkg: FSM state encoding, default peripheral map and index sizing helper
// shared by apb_decode_router and apb_decode_match.
package apb_decode_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_ERR    = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_SETUP  = S_SETUP;
  localparam logic [1:0] ST_ACCESS = S_ACCESS;
  localparam logic [1:0] ST_ERR    = S_ERR;

  localparam int unsigned DEF_NUM_SUB = 11;

  // Port 0 sits in the least significant slice.
  localparam logic [11*32-1:0] DEF_SUB_BASE = {
    32'h8f00_f800, 32'h8f00_f000, 32'h8f00_d000, 32'h8f00_c000,
    32'h8f00_b000, 32'h8f00_a000, 32'h8f00_9000, 32'h8f00_0840,
    32'h8f00_0800, 32'h8f00_0600, 32'h8f00_0000
  };

  localparam logic [11*32-1:0] DEF_SUB_MASK = {
    32'hffff_f800, 32'hffff_f800, 32'hffff_f000, 32'hffff_f000,
    32'hffff_f000, 32'hffff_f000, 32'hffff_f000, 32'hffff_ffc0,
    32'hffff_ffc0, 32'hffff_ffc0, 32'hffff_ff00
  };

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $unsigned($clog2(n));
  endfunction

endpackage

// File: rtl/apb_decode_match.sv
// apb_decode_match: base/mask compare against every subordinate window and a
// lowest-index-wins priority encoder.
module apb_decode_match
  import apb_decode_pkg::*;
#(
  parameter int unsigned             NUM_SUB  = DEF_NUM_SUB,
  parameter int unsigned             AW       = 32,
  parameter logic [NUM_SUB*AW-1:0]   SUB_BASE = DEF_SUB_BASE,
  parameter logic [NUM_SUB*AW-1:0]   SUB_MASK = DEF_SUB_MASK,
  localparam int unsigned            IW       = idx_width(NUM_SUB)
) (
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = int'(NUM_SUB) - 1; i >= 0; i--) begin
      if ((addr_i & SUB_MASK[i*AW +: AW]) == SUB_BASE[i*AW +: AW]) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end else begin
        hit_o = hit_o;
        idx_o = idx_o;
      end
    end
  end

endmodule

// File: rtl/apb_decode_router.sv
// apb_decode_router: APB4 manager-to-subordinate router with a programmable map,
// registered select path, decode-error response and (APB_DECODE_TIMEOUT_EN) access watchdog.
module apb_decode_router
  import apb_decode_pkg::*;
#(
  parameter int unsigned           NUM_SUB     = DEF_NUM_SUB,
  parameter int unsigned           AW          = 32,
  parameter int unsigned           DW          = 32,
  parameter logic [NUM_SUB*AW-1:0] SUB_BASE    = DEF_SUB_BASE,
  parameter logic [NUM_SUB*AW-1:0] SUB_MASK    = DEF_SUB_MASK,
  parameter int unsigned           TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_mgr_i,
  input  logic                  penable_mgr_i,
  input  logic                  pwrite_mgr_i,
  input  logic [AW-1:0]         paddr_mgr_i,
  input  logic [DW-1:0]         pwdata_mgr_i,
  input  logic [DW/8-1:0]       pstrb_mgr_i,
  output logic [DW-1:0]         prdata_mgr_o,
  output logic                  pready_mgr_o,
  output logic                  pslverr_mgr_o,
  output logic [NUM_SUB-1:0]    psel_sub_o,
  output logic                  penable_sub_o,
  output logic                  pwrite_sub_o,
  output logic [AW-1:0]         paddr_sub_o,
  output logic [DW-1:0]         pwdata_sub_o,
  output logic [DW/8-1:0]       pstrb_sub_o,
  input  logic [NUM_SUB*DW-1:0] prdata_sub_i,
  input  logic [NUM_SUB-1:0]    pready_sub_i,
  input  logic [NUM_SUB-1:0]    pslverr_sub_i,
  output logic                  decerr_o,
  output logic                  tout_o
);

  localparam int unsigned IW = idx_width(NUM_SUB);

  if ((TIMEOUT_CYC < 32'd2) || (NUM_SUB < 32'd1) || (NUM_SUB > 32'd32)) begin : g_bad_cfg
    $error("apb_decode_router: unsupported NUM_SUB or TIMEOUT_CYC");
  end

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               decerr_q, decerr_d;
  logic               tout_q, tout_d;
  logic               match_hit_s;
  logic [IW-1:0]      match_idx_s;
  logic               timeout_s;
  logic [NUM_SUB-1:0] sel_onehot_s;

  apb_decode_match #(
    .NUM_SUB  (NUM_SUB),
    .AW       (AW),
    .SUB_BASE (SUB_BASE),
    .SUB_MASK (SUB_MASK)
  ) u_match (
    .addr_i (paddr_mgr_i),
    .hit_o  (match_hit_s),
    .idx_o  (match_idx_s)
  );

  assign pwrite_sub_o = pwrite_mgr_i;
  assign paddr_sub_o  = paddr_mgr_i;
  assign pwdata_sub_o = pwdata_mgr_i;
  assign pstrb_sub_o  = pstrb_mgr_i;
  assign decerr_o     = decerr_q;
  assign tout_o       = tout_q;

`ifdef APB_DECODE_TIMEOUT_EN
  localparam int unsigned   CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_s = (state_q == ST_ACCESS) && (cnt_q == CNT_LAST);

  // Saturating access-phase counter: cleared in SETUP, held once it hits the limit.
  always_comb begin
    if (state_q == ST_SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !timeout_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  always_comb begin
    sel_onehot_s = '0;
    for (int i = 0; i < int'(NUM_SUB); i++) begin
      sel_onehot_s[i] = (idx_q == IW'(i));
    end
  end

  // Next-state logic; decerr/tout are registered so they line up with the ERR cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    decerr_d = 1'b0;
    tout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel_mgr_i && !penable_mgr_i) begin
          idx_d = match_idx_s;
          if (match_hit_s) begin
            state_d = ST_SETUP;
          end else begin
            state_d  = ST_ERR;
            decerr_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (psel_mgr_i) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!psel_mgr_i || pready_sub_i[idx_q]) begin
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          state_d = ST_ERR;
          tout_d  = 1'b1;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      decerr_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      decerr_q <= decerr_d;
      tout_q   <= tout_d;
    end
  end

  // A manager that abandons the transfer mid-access gets no response routed back.
  always_comb begin
    psel_sub_o    = '0;
    penable_sub_o = 1'b0;
    pready_mgr_o  = 1'b0;
    pslverr_mgr_o = 1'b0;
    prdata_mgr_o  = '0;
    case (state_q)
      ST_SETUP: begin
        psel_sub_o = sel_onehot_s;
      end
      ST_ACCESS: begin
        psel_sub_o    = sel_onehot_s;
        penable_sub_o = 1'b1;
        if (psel_mgr_i) begin
          prdata_mgr_o  = prdata_sub_i[int'(idx_q)*DW +: DW];
          pready_mgr_o  = pready_sub_i[idx_q];
          pslverr_mgr_o = pslverr_sub_i[idx_q];
        end else begin
          pready_mgr_o  = 1'b0;
        end
      end
      ST_ERR: begin
        pready_mgr_o  = 1'b1;
        pslverr_mgr_o = 1'b1;
      end
      default: begin
        psel_sub_o = '0;
      end
    endcase
  end

endmodule

// File: doc/apb_decode_router.md
# apb_decode_router

Parametrised APB4 address decoder/router between the AXI-to-APB bridge manager port and NUM_SUB peripheral subordinates. It replaces the fixed-map combinational decoder with a programmable base/mask table and a registered, state-machine-driven select path. It also provides a clean decode-error response and a per-transfer timeout watchdog, so a hung subordinate cannot stall the bus.

## Interface
- NUM_SUB, 11: number of subordinate ports (1..32)
- AW, 32: APB address width
- DW, 32: APB data width (multiple of 8)
- SUB_BASE, NUM_SUB×AW packed; default is the peripheral map: 8f00_0000, 8f00_0600, 8f00_0800, 8f00_0840, 8f00_9000, 8f00_a000, 8f00_b000, 8f00_c000, 8f00_d000, 8f00_f000, 8f00_f800. Meaning: per-port base address.
- SUB_MASK, NUM_SUB×AW packed; default ffff_ff00, ffff_ffc0, ffff_ffc0, ffff_ffc0, ffff_f000 ×5, ffff_f800 ×2. Meaning: per-port compare mask.
- TIMEOUT_CYC, 1024: access-phase cycles before timeout (≥2)
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- psel_mgr_i, penable_mgr_i, pwrite_mgr_i  in  1 each  manager control
- paddr_mgr_i  in  AW  manager address
- pwdata_mgr_i  in  DW  manager write data
- pstrb_mgr_i  in  DW/8  manager strobes
- prdata_mgr_o  out  DW  read data to manager
- pready_mgr_o, pslverr_mgr_o  out  1 each  manager response
- psel_sub_o  out  NUM_SUB  one-hot subordinate select
- penable_sub_o, pwrite_sub_o  out  1 each  broadcast control
- paddr_sub_o  out  AW, pwdata_sub_o  out  DW, pstrb_sub_o  out  DW/8  broadcast from manager
- prdata_sub_i  in  NUM_SUB×DW  packed read data (port i at [i*DW +: DW])
- pready_sub_i, pslverr_sub_i  in  NUM_SUB each  subordinate responses
- decerr_o  out  1  one-cycle pulse on decode miss
- tout_o  out  1  one-cycle pulse on timeout

## Operation
- Match: port i hits when (paddr_mgr_i & SUB_MASK[i]) == SUB_BASE[i]. On overlapping hits, the lowest index wins.
- The address, data, strobe and write signals are passed through combinationally. The manager holds them stable for the whole transfer, as APB requires.
- FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE: on psel_mgr_i & ~penable_mgr_i, register the match result (index and hit).
  - Hit → SETUP.
  - Miss → ERR.
- SETUP: drive psel_sub_o[idx]=1 and penable_sub_o=0. Clear the timeout counter. → ACCESS.
- ACCESS: drive psel_sub_o[idx]=1 and penable_sub_o=1. Route prdata, pready and pslverr from port idx combinationally to the manager.
  - pready_sub_i[idx] → IDLE.
  - Counter reaching TIMEOUT_CYC-1 → ERR, with tout_o pulsed in the ERR cycle. The timeout path exists only when the macro below is defined.
- ERR: pready_mgr_o=1, pslverr_mgr_o=1, prdata_mgr_o=0, all psel_sub_o=0. → IDLE. decerr_o pulses here on a miss.
- Manager drops psel_mgr_i in SETUP or ACCESS (protocol violation): → IDLE next cycle, all psel_sub_o cleared, no response generated.
- Outside ACCESS and ERR, pready_mgr_o, pslverr_mgr_o and prdata_mgr_o are 0.

## Timing
- Reset: state IDLE; all psel_sub_o, penable_sub_o, pready_mgr_o, pslverr_mgr_o, decerr_o and tout_o are 0; prdata_mgr_o=0; counter=0.
- Reset asserted mid-transfer: on the next edge, everything returns to the reset values and the subordinate select drops. The manager sees no pready.
- Hit latency: manager setup at T0; subordinate setup at T1; subordinate access from T2. Minimum manager transfer is 3 cycles (1 added wait state versus direct decode).
- Miss: completes at T1 with slverr, a 2-cycle transfer.
- Timeout: the error cycle is exactly TIMEOUT_CYC cycles after first entering ACCESS.
- Back-to-back: a new setup is accepted in the IDLE cycle that follows completion.
- The counter is log2(TIMEOUT_CYC) bits and saturating; it does not wrap.

## Configuration
- APB_DECODE_TIMEOUT_EN defined: the watchdog counter, the ACCESS→ERR timeout transition and the tout_o pulse are compiled in.
- Not defined: the counter is removed, ACCESS waits indefinitely for pready, and tout_o is tied to 0.

## Structure
- Package apb_decode_pkg holds:
  - the state enum type;
  - the default SUB_BASE/SUB_MASK map constants;
  - the index-width function ($clog2 of NUM_SUB, minimum 1).
- Sub-module apb_decode_match: combinational base/mask compare and priority encoder, outputting hit and idx.

## Test plan
- Read at 8f00_b004 with uart0 (port 6) returning 1234_5678 and pready on its first access cycle → psel_sub_o=0x040 at T1; manager completes at T2 with prdata 1234_5678 and pslverr 0.
- Write to 8f00_e000 (unmapped) → no psel_sub_o; at T1 pready=1, pslverr=1, prdata=0; decerr_o pulses at T1.
- Subordinate 9 holds pready low (TIMEOUT_CYC=16, macro defined) → at ACCESS entry +16 pready=1, pslverr=1, tout_o=1, psel_sub_o=0; IDLE the next cycle.
- Same stimulus with the macro undefined → transfer stays in ACCESS for 100 cycles, then completes normally when pready rises; tout_o is never 1.
- Override overlapping ports 0 and 1 at base 8f00_0000 → access to 8f00_0010 selects port 0 only.
- Assert rst_i during ACCESS → the next cycle shows all outputs at reset values; the following transfer to port 2 proceeds normally.
